// File: rtl/ula_mant_seq.sv
// ula_mant_seq: sequential mantissa multiply (shift-add) / divide (restoring), one bit per clock.
// Optional feature: define ULA_STICKY_EN to turn dout[0] into a sticky bit for FPU rounding.
module ula_mant_seq #(
    parameter int MANT_W = 24,
    parameter int OUT_W  = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MANT_W-1:0] a,
    input  logic [MANT_W-1:0] b,
    input  logic              multiplica,
    input  logic              start,
    output logic [OUT_W-1:0]  dout,
    output logic              c_out,
    output logic              finish,
    output logic              busy
);
    localparam int PW = 2 * MANT_W;
    localparam int CW = $clog2(OUT_W + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [MANT_W-1:0] a_r;
    logic [MANT_W-1:0] b_r;
    logic [PW-1:0]     p;
    logic [PW-1:0]     p_nxt;
    logic [MANT_W:0]   mul_sum;
    logic [MANT_W:0]   rem;
    logic [MANT_W:0]   div_rem;
    logic [OUT_W-1:0]  quo;
    logic [OUT_W-1:0]  quo_nxt;
    logic [OUT_W-1:0]  mul_res;
    logic [OUT_W-1:0]  div_res;
    logic              div_ge;
    logic              sat;

    // Next-step values of both iterations; the last step feeds dout directly.
    always_comb begin
        mul_sum = {1'b0, p[PW-1:MANT_W]} + (p[0] ? {1'b0, a_r} : '0);
        p_nxt   = {mul_sum, p[MANT_W-1:1]};
        div_ge  = rem >= {1'b0, b_r};
        div_rem = div_ge ? rem - {1'b0, b_r} : rem;
        quo_nxt = {quo[OUT_W-2:0], div_ge};
`ifdef ULA_STICKY_EN
        mul_res = {p_nxt[PW-1 -: OUT_W-1], p_nxt[PW-OUT_W] | (|p_nxt[PW-OUT_W-1:0])};
        div_res = {quo_nxt[OUT_W-1:1], quo_nxt[0] | (|div_rem)};
`else
        mul_res = p_nxt[PW-1 -: OUT_W];
        div_res = quo_nxt;
`endif
        sat     = (b == '0) || ({1'b0, a} >= {b, 1'b0});
    end

    // Control FSM with registered outputs; results only land on the edge entering DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            p      <= '0;
            rem    <= '0;
            quo    <= '0;
            dout   <= '0;
            c_out  <= 1'b0;
            finish <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        a_r  <= a;
                        b_r  <= b;
                        p    <= {{MANT_W{1'b0}}, b};
                        rem  <= {1'b0, a};
                        quo  <= '0;
                        if (multiplica) begin
                            state <= MUL;
                            cnt   <= CW'(MANT_W);
                        end else if (sat) begin
                            state  <= DONE;
                            cnt    <= '0;
                            dout   <= '1;
                            c_out  <= 1'b1;
                            finish <= 1'b1;
                        end else begin
                            state <= DIV;
                            cnt   <= CW'(OUT_W);
                        end
                    end
                end
                MUL: begin
                    p   <= p_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state  <= DONE;
                        dout   <= mul_res;
                        c_out  <= p_nxt[PW-1];
                        finish <= 1'b1;
                    end
                end
                DIV: begin
                    rem <= div_rem << 1;
                    quo <= quo_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state  <= DONE;
                        dout   <= div_res;
                        c_out  <= quo_nxt[OUT_W-1];
                        finish <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    finish <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ula_mant_seq.sv
// tb_ula_mant_seq: directed vectors with a scoreboard queue checked by a finish-driven monitor.
module tb_ula_mant_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] a = '0;
    logic [23:0] b = '0;
    logic        multiplica = 1'b0;
    logic        start = 1'b0;
    logic [27:0] dout;
    logic        c_out;
    logic        finish;
    logic        busy;

`ifdef ULA_STICKY_EN
    localparam logic [27:0] MUL_STK = 28'h4000011;
    localparam logic [27:0] DIV_STK = 28'h6666667;
`else
    localparam logic [27:0] MUL_STK = 28'h4000010;
    localparam logic [27:0] DIV_STK = 28'h6666666;
`endif

    typedef struct {
        logic [27:0] d;
        logic        c;
        int          edge_n;
        int          id;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_fin = 0;
    bit   chk_busy_low = 0;
    int   t0;
    int   f0;

    ula_mant_seq dut (
        .clk(clk),
        .rst_n(rst_n),
        .a(a),
        .b(b),
        .multiplica(multiplica),
        .start(start),
        .dout(dout),
        .c_out(c_out),
        .finish(finish),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, act, req);
    endtask

    // Monitor: every finish pulse pops one expected result.
    always @(negedge clk) begin
        if (chk_busy_low) begin
            check("busy_after_finish", {31'b0, busy}, 32'd0);
            chk_busy_low = 0;
        end
        if (finish) begin
            n_fin++;
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_finish at edge %0d: got finish=1 required 0", cyc);
            end else begin
                e = sb.pop_front();
                check($sformatf("op%0d_dout", e.id), {4'b0, dout}, {4'b0, e.d});
                check($sformatf("op%0d_c_out", e.id), {31'b0, c_out}, {31'b0, e.c});
                check($sformatf("op%0d_finish_edge", e.id), cyc, e.edge_n);
                chk_busy_low = 1;
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 64 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        #1;
    endtask

    task automatic run_op(input int id, input logic [23:0] ai, input logic [23:0] bi,
                          input logic m, input logic [27:0] d, input logic c, input int lat);
        a = ai;
        b = bi;
        multiplica = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back('{d, c, cyc + lat, id});
        check($sformatf("op%0d_busy", id), {31'b0, busy}, 32'd1);
        a = ~ai;
        b = ~bi;
        multiplica = ~m;
        drain();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", {4'b0, dout}, 32'd0);
        check("rst_c_out", {31'b0, c_out}, 32'd0);
        check("rst_finish", {31'b0, finish}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(1,  24'h800000, 24'h800000, 1'b1, 28'h4000000, 1'b0, 24);
        run_op(2,  24'hC00000, 24'hC00000, 1'b1, 28'h9000000, 1'b1, 24);
        run_op(3,  24'hFFFFFF, 24'h800001, 1'b1, 28'h8000007, 1'b1, 24);
        run_op(4,  24'h800001, 24'h800001, 1'b1, MUL_STK,     1'b0, 24);
        run_op(5,  24'h800000, 24'h800000, 1'b0, 28'h8000000, 1'b1, 28);
        run_op(6,  24'h800000, 24'hC00000, 1'b0, 28'h5555555, 1'b0, 28);
        run_op(7,  24'h800000, 24'hA00000, 1'b0, DIV_STK,     1'b0, 28);
        run_op(8,  24'hFFFFFF, 24'h800000, 1'b0, 28'hFFFFFF0, 1'b1, 28);
        run_op(9,  24'h123456, 24'h000000, 1'b0, 28'hFFFFFFF, 1'b1, 0);
        run_op(10, 24'hFFFFFF, 24'h7FFFFF, 1'b0, 28'hFFFFFFF, 1'b1, 0);
        run_op(11, 24'h800000, 24'h400000, 1'b0, 28'hFFFFFFF, 1'b1, 0);

        // start pulse with new operands mid-multiply must be ignored
        f0 = n_fin;
        a = 24'hC00000;
        b = 24'hC00000;
        multiplica = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back('{28'h9000000, 1'b1, cyc + 24, 12});
        repeat (5) @(posedge clk);
        #1;
        a = 24'h800000;
        b = 24'h800000;
        multiplica = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        repeat (30) @(posedge clk);
        #1;
        check("midstart_finish_count", n_fin - f0, 32'd1);

        // reset at cycle 10 of a second run aborts it silently
        a = 24'h800000;
        b = 24'h800000;
        multiplica = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        f0 = n_fin;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_dout", {4'b0, dout}, 32'd0);
        check("abort_c_out", {31'b0, c_out}, 32'd0);
        check("abort_finish", {31'b0, finish}, 32'd0);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_finish", n_fin - f0, 32'd0);

        // start held high: second op accepted the cycle after the first finish
        f0 = n_fin;
        a = 24'h800000;
        b = 24'h800000;
        multiplica = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        sb.push_back('{28'h8000000, 1'b1, t0 + 28, 13});
        sb.push_back('{MUL_STK, 1'b0, t0 + 30 + 24, 14});
        a = 24'h800001;
        b = 24'h800001;
        multiplica = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        repeat (10) @(posedge clk);
        #1;
        check("b2b_finish_count", n_fin - f0, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
